branch_hazard_ctrl: RTL and testbench

BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

---
 rtl/branch_hazard_ctrl.sv | 96 +++++++++
 tb/tb_branch_hazard_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: branch squash, load-use stall and jump redirect control with saturating event counters
module branch_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Branch_EX,
  input  logic             zero_EX,
  input  logic             MemRead_EX,
  input  logic [4:0]       rt_EX,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             UseRt_ID,
  input  logic             Jump_ID,
  input  logic             clr_cnt,
  output logic [1:0]       pc_sel,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, SQUASH = 2'b10} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d, stall_cnt_q, stall_cnt_d;
  logic taken, hazard, fire_taken, fire_stall;
  assign taken  = Branch_EX & zero_EX;
  assign hazard = MemRead_EX & (rt_EX != 5'd0) & ((rt_EX == rs_ID) | (UseRt_ID & (rt_EX == rt_ID)));
  // Next state and pipeline controls; reset overrides so the pipe is frozen and flushed while rst_n is low
  always_comb begin
    state_d    = RUN;
    pc_sel     = 2'b00;
    PCWrite    = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    fire_taken = 1'b0;
    fire_stall = 1'b0;
    case (state_q)
      RUN: begin
        if (taken) begin
          pc_sel     = 2'b01;
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
          state_d    = SQUASH;
          fire_taken = 1'b1;
        end else if (hazard) begin
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          IDEX_Flush = 1'b1;
          state_d    = STALL;
          fire_stall = 1'b1;
        end else if (Jump_ID) begin
          pc_sel     = 2'b10;
          IFID_Flush = 1'b1;
        end
      end
      STALL: begin
        if (Jump_ID) begin
          pc_sel     = 2'b10;
          IFID_Flush = 1'b1;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_sel     = 2'b00;
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
      fire_taken = 1'b0;
      fire_stall = 1'b0;
    end
  end
  // Saturating counters with clear taking priority over a same-cycle increment
  always_comb begin
    taken_cnt_d = clr_cnt ? '0 : (fire_taken && taken_cnt_q != '1) ? taken_cnt_q + CNT_W'(1) : taken_cnt_q;
    stall_cnt_d = clr_cnt ? '0 : (fire_stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  // State and counter registers, cleared immediately on reset assertion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign taken_cnt = taken_cnt_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: directed checks of redirect, stall, squash, counters and reset
module tb_branch_hazard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic Branch_EX, zero_EX, MemRead_EX, UseRt_ID, Jump_ID, clr_cnt;
  logic [4:0] rt_EX, rs_ID, rt_ID;
  logic [1:0] pc_sel, pc_sel_s;
  logic PCWrite, IFID_Write, IFID_Flush, IDEX_Flush;
  logic PCWrite_s, IFID_Write_s, IFID_Flush_s, IDEX_Flush_s;
  logic [15:0] taken_cnt, stall_cnt;
  logic [3:0] taken_cnt_s, stall_cnt_s;
  logic [5:0] o;
  int n_chk = 0, n_fail = 0;
  localparam logic [5:0] O_DEF = 6'h0C, O_RST = 6'h03, O_BR = 6'h1F, O_STL = 6'h01, O_JMP = 6'h2E;
  always #5 clk = ~clk;
  assign o = {pc_sel, PCWrite, IFID_Write, IFID_Flush, IDEX_Flush};
  branch_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Branch_EX(Branch_EX), .zero_EX(zero_EX), .MemRead_EX(MemRead_EX),
    .rt_EX(rt_EX), .rs_ID(rs_ID), .rt_ID(rt_ID), .UseRt_ID(UseRt_ID), .Jump_ID(Jump_ID), .clr_cnt(clr_cnt),
    .pc_sel(pc_sel), .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );
  branch_hazard_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .Branch_EX(Branch_EX), .zero_EX(zero_EX), .MemRead_EX(MemRead_EX),
    .rt_EX(rt_EX), .rs_ID(rs_ID), .rt_ID(rt_ID), .UseRt_ID(UseRt_ID), .Jump_ID(Jump_ID), .clr_cnt(clr_cnt),
    .pc_sel(pc_sel_s), .PCWrite(PCWrite_s), .IFID_Write(IFID_Write_s), .IFID_Flush(IFID_Flush_s),
    .IDEX_Flush(IDEX_Flush_s), .taken_cnt(taken_cnt_s), .stall_cnt(stall_cnt_s)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    Branch_EX = 0; zero_EX = 0; MemRead_EX = 0; UseRt_ID = 0; Jump_ID = 0; clr_cnt = 0;
    rt_EX = 0; rs_ID = 0; rt_ID = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_use();
    MemRead_EX = 1; rt_EX = 5'd5; rt_ID = 5'd5; UseRt_ID = 1; rs_ID = 5'd0;
  endtask
  initial begin
    idle();
    #3;
    chk("rst_outs", o, O_RST);
    chk("rst_taken", taken_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    tick(); tick();
    #4 rst_n = 1;
    tick();
    #4 chk("idle", o, O_DEF);
    tick();
    Branch_EX = 1; zero_EX = 1;
    #4 chk("br_taken", o, O_BR);
    tick();
    load_use(); Jump_ID = 1;
    #4 chk("squash_def", o, O_DEF);
    chk("taken_1", taken_cnt, 1);
    chk("squash_nostall", stall_cnt, 0);
    tick();
    idle(); Branch_EX = 1;
    #4 chk("br_not_taken", o, O_DEF);
    tick();
    chk("taken_keep", taken_cnt, 1);
    idle(); load_use();
    #4 chk("lu_rt", o, O_STL);
    tick();
    #4 chk("stall_ignores_hz", o, O_DEF);
    chk("stall_1", stall_cnt, 1);
    idle();
    tick();
    load_use(); rt_EX = 0; rt_ID = 0;
    #4 chk("rt0_nostall", o, O_DEF);
    load_use(); UseRt_ID = 0;
    #1 chk("no_usert", o, O_DEF);
    rs_ID = 5'd5;
    #1 chk("lu_rs", o, O_STL);
    tick();
    idle();
    #4 chk("stall_2", stall_cnt, 2);
    tick();
    load_use(); Branch_EX = 1; zero_EX = 1; Jump_ID = 1;
    #4 chk("simul_branch", o, O_BR);
    tick();
    Branch_EX = 0; zero_EX = 0;
    chk("simul_stall_keep", stall_cnt, 2);
    chk("taken_2", taken_cnt, 2);
    #4 chk("squash_def2", o, O_DEF);
    tick();
    #4 chk("lu_after_squash", o, O_STL);
    tick();
    #4 chk("jump_in_stall", o, O_JMP);
    chk("stall_3", stall_cnt, 3);
    idle(); Jump_ID = 1;
    tick();
    #4 chk("jump_run", o, O_JMP);
    idle();
    tick();
    load_use(); clr_cnt = 1;
    #4 chk("clr_stall_outs", o, O_STL);
    tick();
    idle();
    chk("clr_stall", stall_cnt, 0);
    chk("clr_taken", taken_cnt, 0);
    chk("clr_small", stall_cnt_s, 0);
    tick();
    for (int i = 0; i < 15; i++) begin
      load_use(); tick(); idle(); tick();
    end
    chk("small_15", stall_cnt_s, 15);
    for (int i = 0; i < 2; i++) begin
      load_use(); tick(); idle(); tick();
    end
    chk("small_sat", stall_cnt_s, 15);
    chk("big_17", stall_cnt, 17);
    load_use();
    tick();
    #1 rst_n = 0;
    #1 chk("rst_mid_outs", o, O_RST);
    chk("rst_mid_stall", stall_cnt, 0);
    idle();
    tick();
    #4 rst_n = 1;
    Branch_EX = 1; zero_EX = 1;
    #1 chk("post_rst_br", o, O_BR);
    tick();
    idle();
    #4 chk("post_rst_squash", o, O_DEF);
    chk("post_rst_taken", taken_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
